// File: rtl/ps2_dir_decoder_if.sv
// rtl/ps2_dir_decoder_if.sv - PS/2 byte input, direction state and key event queue signals
interface ps2_dir_decoder_if;
    logic       key_valid;
    logic [7:0] key_data;
    logic [1:0] dir;
    logic       dir_active;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       evt_ready;
    logic       overflow;
    logic       ovf_clr;

    modport master (
        output key_valid, key_data, evt_ready, ovf_clr,
        input  dir, dir_active, evt_valid, evt_data, overflow
    );

    modport slave (
        input  key_valid, key_data, evt_ready, ovf_clr,
        output dir, dir_active, evt_valid, evt_data, overflow
    );
endinterface

// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 scancode to held-direction register and key event queue
// Optional WASD_KEYS_EN: also decode non-extended W/S/A/D onto the arrow held bits.
module ps2_dir_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic             clock,
    input logic             resetn,
    ps2_dir_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t        state, state_nxt;
    logic          dec_en, dec_ext, dec_brk;
    logic          key_hit;
    logic [1:0]    key_idx;
    logic [3:0]    held, held_nxt;
    logic [1:0]    dir, dir_nxt;
    logic          push;
    logic [2:0]    push_data;

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [2:0]    evt_data, head_nxt;
    logic          overflow;
    logic          pop, full, wr_en, drop;

    always_comb begin
        state_nxt = state;
        dec_en    = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        if (bus.key_valid) begin
            case (state)
                IDLE: begin
                    if (bus.key_data == 8'hE0)      state_nxt = GOT_E0;
                    else if (bus.key_data == 8'hF0) state_nxt = GOT_F0;
                    else                            dec_en = 1'b1;
                end
                GOT_E0: begin
                    if (bus.key_data == 8'hF0)      state_nxt = GOT_E0F0;
                    else if (bus.key_data != 8'hE0) begin
                        dec_en    = 1'b1;
                        dec_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                GOT_F0: begin
                    if (bus.key_data == 8'hE0)      state_nxt = GOT_E0F0;
                    else if (bus.key_data != 8'hF0) begin
                        dec_en    = 1'b1;
                        dec_brk   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (bus.key_data != 8'hE0 && bus.key_data != 8'hF0) begin
                        dec_en    = 1'b1;
                        dec_ext   = 1'b1;
                        dec_brk   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // key_idx doubles as the dir encoding: 0 up, 1 down, 2 left, 3 right
    always_comb begin
        key_hit = 1'b0;
        key_idx = 2'b00;
        if (dec_en && dec_ext) begin
            case (bus.key_data)
                8'h75:   begin key_hit = 1'b1; key_idx = 2'd0; end
                8'h72:   begin key_hit = 1'b1; key_idx = 2'd1; end
                8'h6B:   begin key_hit = 1'b1; key_idx = 2'd2; end
                8'h74:   begin key_hit = 1'b1; key_idx = 2'd3; end
                default: key_hit = 1'b0;
            endcase
        end
`ifdef WASD_KEYS_EN
        if (dec_en && !dec_ext) begin
            case (bus.key_data)
                8'h1D:   begin key_hit = 1'b1; key_idx = 2'd0; end
                8'h1B:   begin key_hit = 1'b1; key_idx = 2'd1; end
                8'h1C:   begin key_hit = 1'b1; key_idx = 2'd2; end
                8'h23:   begin key_hit = 1'b1; key_idx = 2'd3; end
                default: key_hit = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        held_nxt  = held;
        dir_nxt   = dir;
        push      = 1'b0;
        push_data = 3'b000;
        if (key_hit) begin
            if (!dec_brk) begin
                if (!held[key_idx]) begin
                    held_nxt[key_idx] = 1'b1;
                    dir_nxt           = key_idx;
                    push              = 1'b1;
                    push_data         = {1'b0, key_idx};
                end
            end else if (held[key_idx]) begin
                held_nxt[key_idx] = 1'b0;
                push              = 1'b1;
                push_data         = {1'b1, key_idx};
                // Fall back to the lowest still-held key when the active one is released
                if (key_idx == dir) begin
                    if (held_nxt[0])      dir_nxt = 2'd0;
                    else if (held_nxt[1]) dir_nxt = 2'd1;
                    else if (held_nxt[2]) dir_nxt = 2'd2;
                    else if (held_nxt[3]) dir_nxt = 2'd3;
                end
            end
        end
    end

    always_comb begin
        pop        = bus.evt_ready && (count != '0);
        full       = (count == CW'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        drop       = push && full && !pop;
        wr_ptr_nxt = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        case ({wr_en, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // Head register is preloaded so evt_data is a flop, bypassing the entry being written
        head_nxt = evt_data;
        if (count_nxt != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_nxt)) head_nxt = push_data;
            else                                 head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            held     <= 4'b0000;
            dir      <= 2'b00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            evt_data <= 3'b000;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            held     <= held_nxt;
            dir      <= dir_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            evt_data <= head_nxt;
            if (drop)             overflow <= 1'b1;
            else if (bus.ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign bus.dir        = dir;
    assign bus.dir_active = |held;
    assign bus.evt_valid  = (count != '0);
    assign bus.evt_data   = evt_data;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb/tb_ps2_dir_decoder.sv - randomized and directed checks of ps2_dir_decoder against a scancode model
module tb_ps2_dir_decoder;
    localparam int DEPTH = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    ps2_dir_decoder_if bus();

    ps2_dir_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    bit m_ext, m_brk, m_ovf;
    bit m_held [4];
    int m_dir;
    int m_q [$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int key_of(input bit ext, input logic [7:0] c);
        if (ext) begin
            case (c)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
`ifdef WASD_KEYS_EN
        case (c)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
`else
        return -1;
`endif
    endfunction

    function automatic bit any_held();
        return m_held[0] | m_held[1] | m_held[2] | m_held[3];
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_dir = 0;
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_q.delete();
    endtask

    task automatic compare_all(input string ctx);
        int head;
        chk({ctx, ".dir"}, bus.dir, 8'(m_dir));
        chk({ctx, ".dir_active"}, bus.dir_active, 8'(any_held()));
        chk({ctx, ".evt_valid"}, bus.evt_valid, 8'(m_q.size() != 0));
        chk({ctx, ".overflow"}, bus.overflow, 8'(m_ovf));
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk({ctx, ".evt_data"}, bus.evt_data, 8'(head));
        end
    endtask

    task automatic step(input string ctx, input bit kv, input logic [7:0] kd, input bit rdy, input bit clr);
        int  push_v;
        int  k;
        bit  pop, full;
        @(negedge clock);
        bus.key_valid = kv;
        bus.key_data  = kd;
        bus.evt_ready = rdy;
        bus.ovf_clr   = clr;
        @(posedge clock);
        push_v = -1;
        if (kv) begin
            if (kd == 8'hE0) m_ext = 1;
            else if (kd == 8'hF0) m_brk = 1;
            else begin
                k = key_of(m_ext, kd);
                if (k >= 0) begin
                    if (!m_brk) begin
                        if (!m_held[k]) begin
                            m_held[k] = 1;
                            m_dir     = k;
                            push_v    = k;
                        end
                    end else if (m_held[k]) begin
                        m_held[k] = 0;
                        push_v    = 4 + k;
                        if (k == m_dir)
                            for (int i = 3; i >= 0; i--) if (m_held[i]) m_dir = i;
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
        pop  = rdy && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        if (pop) void'(m_q.pop_front());
        if (push_v >= 0 && full && !pop) m_ovf = 1;
        else begin
            if (push_v >= 0) m_q.push_back(push_v);
            if (clr) m_ovf = 0;
        end
        #1;
        compare_all(ctx);
    endtask

    task automatic key(input string ctx, input logic [7:0] kd);
        step(ctx, 1'b1, kd, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clock);
        resetn        = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #3;
        model_reset();
        chk({ctx, ".rst_dir"}, bus.dir, 8'h00);
        chk({ctx, ".rst_active"}, bus.dir_active, 8'h00);
        chk({ctx, ".rst_valid"}, bus.evt_valid, 8'h00);
        chk({ctx, ".rst_data"}, bus.evt_data, 8'h00);
        chk({ctx, ".rst_ovf"}, bus.overflow, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'hE0};

    initial begin
        logic [7:0] b;
        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        model_reset();
        do_reset("init");

        key("up_mk", 8'hE0); key("up_mk", 8'h75);
        chk("tp1.dir", bus.dir, 8'h00);
        chk("tp1.active", bus.dir_active, 8'h01);
        chk("tp1.evt", bus.evt_data, 8'h00);
        key("up_br", 8'hE0); key("up_br", 8'hF0); key("up_br", 8'h75);
        chk("tp1.released", bus.dir_active, 8'h00);
        step("tp1_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("tp1.evt2", bus.evt_data, 8'h04);

        do_reset("tp2");
        for (int i = 0; i < 6; i++) begin
            key("rep", 8'hE0); key("rep", 8'h6B);
        end
        chk("tp2.dir", bus.dir, 8'h02);
        chk("tp2.evt", bus.evt_data, 8'h02);
        step("tp2_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("tp2.one_evt", bus.evt_valid, 8'h00);

        do_reset("tp3");
        key("l", 8'hE0); key("l", 8'h6B);
        key("d", 8'hE0); key("d", 8'h72);
        key("dr", 8'hE0); key("dr", 8'hF0); key("dr", 8'h72);
        chk("tp3.dir", bus.dir, 8'h02);
        for (int i = 0; i < 3; i++) step("tp3_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        do_reset("tp4");
        key("f", 8'hE0); key("f", 8'h75);
        key("f", 8'hE0); key("f", 8'h72);
        key("f", 8'hE0); key("f", 8'h6B);
        key("f", 8'hE0); key("f", 8'h74);
        key("f", 8'hE0); key("f", 8'hF0); key("f", 8'h75);
        chk("tp4.ovf_set", bus.overflow, 8'h01);
        chk("tp4.head", bus.evt_data, 8'h00);
        step("tp4_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("tp4.ovf_clr", bus.overflow, 8'h00);
        key("pp", 8'hE0); key("pp", 8'hF0);
        step("tp4_pp", 1'b1, 8'h72, 1'b1, 1'b0);
        chk("tp4.pp_ovf", bus.overflow, 8'h00);
        chk("tp4.pp_head", bus.evt_data, 8'h01);
        step("tp4_both", 1'b0, 8'h00, 1'b0, 1'b1);

        do_reset("tp5");
        key("pre", 8'hE0);
        do_reset("tp5_mid");
        key("after", 8'h75);
        chk("tp5.valid", bus.evt_valid, 8'h00);
        chk("tp5.active", bus.dir_active, 8'h00);

        do_reset("tp6");
        key("wasd", 8'h1C);
`ifdef WASD_KEYS_EN
        chk("tp6.dir", bus.dir, 8'h02);
        chk("tp6.evt", bus.evt_data, 8'h02);
`else
        chk("tp6.valid", bus.evt_valid, 8'h00);
        chk("tp6.active", bus.dir_active, 8'h00);
`endif

        do_reset("rnd");
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset("rnd_mid");
            b = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            step("rnd", $urandom_range(0, 2) != 0, b,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
